nios2_system_cpu_cpu_debug_mem_ctrl: RTL and testbench
======================================================

Name: nios2_system_cpu_cpu_debug_mem_ctrl

Overview:
Consumes the sysclk-domain debug-slave outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) and executes JTAG read/write commands on the CPU's on-chip debug memory. The same memory is shared with the CPU's Avalon debug-monitor port. Returns MonDReg, monitor_ready and monitor_error back into the debug slave's tck readback. JTAG has priority over Avalon.

Parameters:
ADDR_W, 8, word-address width of debug RAM (2**ADDR_W 32-bit words)
ROM_WORDS, 64, size of write-protected low region (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data-out shift-register snapshot
take_action_ocimem_a  in  1  one-cycle pulse: load address/control
take_action_ocimem_b  in  1  one-cycle pulse: JTAG write request
take_no_action_ocimem_a  in  1  one-cycle pulse: JTAG read request
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  last JTAG command complete
monitor_error  out  1  sticky command-overrun / protection error

Behaviour:
- Reset values: MonDReg=0, monitor_ready=0, monitor_error=0, av_readdata=0, av_waitrequest=1; MonAReg=0; request register empty; FSM=IDLE. RAM contents are not reset.
- jdo fields: address = jdo[ADDR_W+16:17]; write data = jdo[34:3]; error-clear = jdo[35].
- take_action_ocimem_a:
  - MonAReg <= address field.
  - monitor_ready <= 0.
  - If jdo[35]=1, monitor_error <= 0.
  - No memory access.
- take_action_ocimem_b: queue write {addr=MonAReg, data=jdo[34:3], all bytes}; monitor_ready <= 0.
- take_no_action_ocimem_a: queue read at MonAReg; monitor_ready <= 0.
- Request register is one deep. A new b/no_action pulse while it is occupied: request dropped, monitor_error <= 1.
- Multiple pulses in one cycle: priority a > b > no_action; the losers are dropped and monitor_error <= 1.
- FSM states: IDLE, JRD, AVRD.
  - IDLE, JTAG write pending: RAM written this cycle; next edge clears request, monitor_ready <= 1, MonAReg += 1. Stay IDLE.
  - IDLE, JTAG read pending: RAM addressed with MonAReg; go to JRD.
  - IDLE, else av_read: RAM addressed with av_address; go to AVRD.
  - IDLE, else av_write: byte-enabled write; av_waitrequest=0 this cycle (single-cycle accept).
  - JRD: MonDReg <= RAM q; monitor_ready <= 1; MonAReg += 1; clear request; go to IDLE.
  - AVRD: av_readdata = RAM q; av_waitrequest=0; go to IDLE.
- Read latency: Avalon read issued in IDLE completes 2 cycles after first assertion if uncontended. JTAG read: MonDReg valid 2 cycles after the pulse.
- av_waitrequest is 1 in every other cycle. A pending JTAG request stalls Avalon; an in-progress AVRD is never aborted.
- MonAReg increment wraps modulo 2**ADDR_W (all-ones -> 0).
- take_action_ocimem_a coinciding with a completion edge: the loaded address wins over the increment, and monitor_ready stays 0.
- Asynchronous reset mid-operation: pending request discarded; an Avalon master sees av_waitrequest=1 until it re-issues.

Optional Feature:
- Macro: OCIMEM_ROM_PROTECT_EN.
- When defined: writes (JTAG or Avalon) to word address < ROM_WORDS do not modify RAM.
  - JTAG case: monitor_error <= 1; monitor_ready <= 1 and MonAReg increments as normal.
  - Avalon case: the write is accepted (waitrequest=0) and discarded silently.
- When undefined: all addresses writable; ROM_WORDS unused.

Decomposition:
- Package nios2_system_cpu_debug_pkg holds:
  - FSM state enum (IDLE/JRD/AVRD)
  - jdo field bit positions (ADDR_LSB=17, DATA_MSB=34, DATA_LSB=3, ERRCLR=35)
  - request-type enum
  - DATA_W=32
- Sub-module nios2_system_cpu_debug_ram: single-port, byte-enabled, 1-cycle registered read, 2**ADDR_W x 32.

Test Plan:
- Load address 0x10 (pulse a, jdo[24:17]=0x10), then pulse b with data 0xDEADBEEF, then pulse a to 0x10 and pulse no_action -> MonDReg=0xDEADBEEF, monitor_ready=1, MonAReg=0x11.
- Address 0xFF, two back-to-back writes spaced 3 cycles apart -> words 0xFF and 0x00 written; MonAReg wraps to 0x01.
- Pulse b twice in consecutive cycles while the first is pending -> second dropped, monitor_error=1. Pulse a with jdo[35]=1 -> monitor_error=0.
- Avalon read of 0x20 in the same cycle a JTAG read is pending -> JTAG served first; av_waitrequest=1 for 2 extra cycles; av_readdata equals RAM[0x20].
- Avalon write 0x12345678 to 0x30 with byteenable=4'b0011 over prior 0xFFFFFFFF -> read back 0xFFFF5678.
- With OCIMEM_ROM_PROTECT_EN: JTAG write 0xA5A5A5A5 to 0x05 -> RAM unchanged, monitor_error=1, monitor_ready=1.

Source files
------------

// File: rtl/nios2_system_cpu_debug_pkg.sv
// Shared types and constants for the on-chip debug memory controller.
//   - FSM state enum, JTAG request-type enum
//   - jdo field bit positions and the debug data width
package nios2_system_cpu_debug_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned JDO_W    = 38;
  localparam int unsigned ADDR_LSB = 17;
  localparam int unsigned DATA_MSB = 34;
  localparam int unsigned DATA_LSB = 3;
  localparam int unsigned ERRCLR   = 35;

  typedef enum logic [1:0] {
    StIdle,
    StJrd,
    StAvrd
  } state_e;

  typedef enum logic {
    ReqRead,
    ReqWrite
  } req_e;

endpackage

// File: rtl/nios2_system_cpu_cpu_debug_mem_ctrl_if.sv
// Bus bundle for the debug memory controller.
//   JTAG side : jdo, take_action_ocimem_a/b, take_no_action_ocimem_a (in),
//               MonDReg, monitor_ready, monitor_error (out)
//   Avalon    : av_address/read/write/writedata/byteenable (in),
//               av_readdata, av_waitrequest (out)
// master = debug slave / CPU side, slave = the controller.
interface nios2_system_cpu_cpu_debug_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  import nios2_system_cpu_debug_pkg::*;

  logic [JDO_W-1:0]  jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [3:0]        av_byteenable;
  logic [DATA_W-1:0] av_readdata;
  logic              av_waitrequest;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest, MonDReg, monitor_ready, monitor_error
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_readdata, av_waitrequest, MonDReg, monitor_ready, monitor_error
  );

endinterface

// File: rtl/nios2_system_cpu_debug_ram.sv
// Single-port debug RAM, 2**ADDR_W x 32, byte-enabled write, registered read.
//   i_clk   : clock
//   i_addr  : word address
//   i_we    : write enable
//   i_be    : byte enables
//   i_wdata : write data
//   o_q     : read data, one cycle after i_addr (read-before-write)
// Contents are not reset.
module nios2_system_cpu_debug_ram #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_q
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/nios2_system_cpu_cpu_debug_mem_ctrl.sv
// Debug memory controller: executes JTAG read/write commands from the debug
// slave on the on-chip debug RAM, sharing it with the Avalon debug-monitor port.
// JTAG requests always win over Avalon; an Avalon read in flight is never aborted.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : slave modport carrying the JTAG pulses/jdo, Avalon port and
//                  MonDReg / monitor_ready / monitor_error readback
// Optional: define OCIMEM_ROM_PROTECT_EN to make words below ROM_WORDS read-only.
module nios2_system_cpu_cpu_debug_mem_ctrl
  import nios2_system_cpu_debug_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ROM_WORDS = 64
) (
  input logic clk,
  input logic reset_n,
  nios2_system_cpu_cpu_debug_mem_ctrl_if.slave bus
);

`ifdef OCIMEM_ROM_PROTECT_EN
  localparam bit RomEn = 1'b1;
`else
  localparam bit RomEn = 1'b0;
`endif

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_mon_a;
  logic [DATA_W-1:0] r_mon_d;
  logic              r_ready, r_error;
  logic              r_req_valid;
  req_e              r_req_type;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_data;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;
  logic              w_done, w_done_err;
  logic [DATA_W-1:0] w_av_readdata;
  logic              w_av_waitrequest;

  // Pulse arbitration: a > b > no_action, losers flagged as errors.
  logic w_pa, w_pb, w_pn, w_conflict, w_enq, w_drop;
  assign w_pa       = bus.take_action_ocimem_a;
  assign w_pb       = bus.take_action_ocimem_b & ~w_pa;
  assign w_pn       = bus.take_no_action_ocimem_a & ~w_pa & ~bus.take_action_ocimem_b;
  assign w_conflict = (bus.take_action_ocimem_a &
                       (bus.take_action_ocimem_b | bus.take_no_action_ocimem_a)) |
                      (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a);
  assign w_enq      = (w_pb | w_pn) & ~r_req_valid;
  assign w_drop     = (w_pb | w_pn) & r_req_valid;

  logic w_unused_jdo;
  assign w_unused_jdo = ^{bus.jdo[JDO_W-1:ERRCLR+1], bus.jdo[DATA_LSB-1:0]};

  logic w_prot_req, w_prot_av;
  assign w_prot_req = RomEn && (32'(r_req_addr) < ROM_WORDS);
  assign w_prot_av  = RomEn && (32'(bus.av_address) < ROM_WORDS);

  always_comb begin
    w_state_d        = r_state;
    w_ram_addr       = r_req_addr;
    w_ram_we         = 1'b0;
    w_ram_be         = 4'hF;
    w_ram_wdata      = r_req_data;
    w_done           = 1'b0;
    w_done_err       = 1'b0;
    w_av_waitrequest = 1'b1;
    w_av_readdata    = '0;
    unique case (r_state)
      StIdle: begin
        if (r_req_valid && r_req_type == ReqWrite) begin
          w_ram_we   = ~w_prot_req;
          w_done     = 1'b1;
          w_done_err = w_prot_req;
        end else if (r_req_valid) begin
          w_state_d = StJrd;
        end else if (bus.av_read) begin
          w_ram_addr = bus.av_address;
          w_state_d  = StAvrd;
        end else if (bus.av_write) begin
          w_ram_addr       = bus.av_address;
          w_ram_we         = ~w_prot_av;
          w_ram_be         = bus.av_byteenable;
          w_ram_wdata      = bus.av_writedata;
          w_av_waitrequest = 1'b0;
        end
      end
      StJrd: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      StAvrd: begin
        w_av_waitrequest = 1'b0;
        w_av_readdata    = w_ram_q;
        w_state_d        = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_mon_a     <= '0;
      r_mon_d     <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_type  <= ReqRead;
      r_req_addr  <= '0;
      r_req_data  <= '0;
    end else begin
      r_state <= w_state_d;
      // w_done implies a valid request, w_enq implies none: never both.
      if (w_done) r_req_valid <= 1'b0;
      if (w_enq) begin
        r_req_valid <= 1'b1;
        r_req_type  <= w_pb ? ReqWrite : ReqRead;
        r_req_addr  <= r_mon_a;
        r_req_data  <= bus.jdo[DATA_MSB:DATA_LSB];
      end
      // A fresh address load overrides the post-command increment.
      if (w_pa) r_mon_a <= bus.jdo[ADDR_LSB +: ADDR_W];
      else if (w_done) r_mon_a <= r_mon_a + 1'b1;
      if (w_pa || w_enq) r_ready <= 1'b0;
      else if (w_done) r_ready <= 1'b1;
      if (w_conflict || w_drop || w_done_err) r_error <= 1'b1;
      else if (w_pa && bus.jdo[ERRCLR]) r_error <= 1'b0;
      if (r_state == StJrd) r_mon_d <= w_ram_q;
    end
  end

  nios2_system_cpu_debug_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (clk),
    .i_addr (w_ram_addr),
    .i_we   (w_ram_we),
    .i_be   (w_ram_be),
    .i_wdata(w_ram_wdata),
    .o_q    (w_ram_q)
  );

  assign bus.av_readdata    = w_av_readdata;
  assign bus.av_waitrequest = w_av_waitrequest;
  assign bus.MonDReg        = r_mon_d;
  assign bus.monitor_ready  = r_ready;
  assign bus.monitor_error  = r_error;

endmodule

// File: tb/tb_nios2_system_cpu_cpu_debug_mem_ctrl.sv
// Self-checking bench for the debug memory controller: a table of Avalon
// write/read vectors followed by hand-written JTAG sequences.
module tb_nios2_system_cpu_cpu_debug_mem_ctrl;
  import nios2_system_cpu_debug_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nios2_system_cpu_cpu_debug_mem_ctrl_if #(.ADDR_W(8)) bus ();

  nios2_system_cpu_cpu_debug_mem_ctrl #(
    .ADDR_W   (8),
    .ROM_WORDS(64)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] ad, input bit clr);
    return (38'(ad) << 17) | (38'(clr) << 35);
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    return 38'(d) << 3;
  endfunction

  task automatic jtag(input bit a, input bit b, input bit n, input logic [37:0] j);
    bus.jdo                     = j;
    bus.take_action_ocimem_a    = a;
    bus.take_action_ocimem_b    = b;
    bus.take_no_action_ocimem_a = n;
    tick();
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic av_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok = 1'b0;
    bus.av_address    = a;
    bus.av_writedata  = d;
    bus.av_byteenable = be;
    bus.av_write      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!bus.av_waitrequest) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.av_write = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL av_wr_timeout addr 0x%02h: got no accept, expected accept", a);
    end
  endtask

  task automatic av_rd(input logic [7:0] a, output logic [31:0] d, output int waits);
    bit ok = 1'b0;
    d     = 'x;
    waits = 0;
    bus.av_address = a;
    bus.av_read    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!bus.av_waitrequest) begin
        d  = bus.av_readdata;
        ok = 1'b1;
        tick();
        break;
      end
      waits++;
      tick();
    end
    bus.av_read = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL av_rd_timeout addr 0x%02h: got no response, expected response", a);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          waits;

    bus.jdo                     = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.av_address              = '0;
    bus.av_read                 = 1'b0;
    bus.av_write                = 1'b0;
    bus.av_writedata            = '0;
    bus.av_byteenable           = '0;
    reset_n                     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_MonDReg", bus.MonDReg, 32'h0);
    check("rst_ready", 32'(bus.monitor_ready), 32'h0);
    check("rst_error", 32'(bus.monitor_error), 32'h0);
    check("rst_readdata", bus.av_readdata, 32'h0);
    check("rst_waitrequest", 32'(bus.av_waitrequest), 32'h1);
    reset_n = 1'b1;
    tick();

    // Avalon vectors: byte-enable merges and preloads for the JTAG sequences
    vecs.push_back('{1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h30, 32'h1234_5678, 4'h3, 32'h0});
    vecs.push_back('{1'b0, 8'h30, 32'h0,         4'h0, 32'hFFFF_5678});
    vecs.push_back('{1'b1, 8'h31, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h31, 32'hAABB_CCDD, 4'hC, 32'h0});
    vecs.push_back('{1'b0, 8'h31, 32'h0,         4'h0, 32'hAABB_0000});
    vecs.push_back('{1'b1, 8'h32, 32'h0,         4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h32, 32'h1122_3344, 4'h5, 32'h0});
    vecs.push_back('{1'b0, 8'h32, 32'h0,         4'h0, 32'h0022_0044});
    vecs.push_back('{1'b1, 8'h32, 32'hFFFF_FFFF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 8'h32, 32'h0,         4'h0, 32'h0022_0044});
    vecs.push_back('{1'b1, 8'h11, 32'h1111_1111, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h01, 32'h0101_0101, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h41, 32'h4141_4141, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 8'h70, 32'h7070_7070, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 8'h20, 32'h0,         4'h0, 32'hCAFE_F00D});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        av_wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      end else begin
        av_rd(vecs[i].addr, rd, waits);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        check($sformatf("vec%0d_wait", i), 32'(waits), 32'd1);
      end
    end

    // JTAG write then read back; MonAReg lands on 0x11
    jtag(1, 0, 0, jdo_addr(8'h10, 1'b0));
    jtag(0, 1, 0, jdo_data(32'hDEAD_BEEF));
    tick();
    tick();
    check("jwr_ready", 32'(bus.monitor_ready), 32'h1);
    jtag(1, 0, 0, jdo_addr(8'h10, 1'b0));
    jtag(0, 0, 1, '0);
    check("jrd_ready_e0", 32'(bus.monitor_ready), 32'h0);
    tick();
    check("jrd_ready_e1", 32'(bus.monitor_ready), 32'h0);
    tick();
    check("jrd_MonDReg", bus.MonDReg, 32'hDEAD_BEEF);
    check("jrd_ready_e2", 32'(bus.monitor_ready), 32'h1);
    jtag(0, 0, 1, '0);
    tick();
    tick();
    check("jrd_autoinc", bus.MonDReg, 32'h1111_1111);

    // Address wrap: writes at 0xFF and 0x00, next read comes from 0x01
    jtag(1, 0, 0, jdo_addr(8'hFF, 1'b0));
    jtag(0, 1, 0, jdo_data(32'hF0F0_F0F0));
    tick();
    tick();
    jtag(0, 1, 0, jdo_data(32'h0F0F_0F0F));
    tick();
    tick();
    jtag(0, 0, 1, '0);
    tick();
    tick();
    check("wrap_MonAReg", bus.MonDReg, 32'h0101_0101);
    check("wrap_no_error", 32'(bus.monitor_error), 32'h0);
    av_rd(8'hFF, rd, waits);
    check("wrap_ram_ff", rd, 32'hF0F0_F0F0);
    av_rd(8'h00, rd, waits);
    check("wrap_ram_00", rd, 32'h0F0F_0F0F);

    // Overrun: second write pulse while first pending is dropped
    jtag(1, 0, 0, jdo_addr(8'h40, 1'b0));
    jtag(0, 1, 0, jdo_data(32'hBBBB_0001));
    jtag(0, 1, 0, jdo_data(32'hBBBB_0002));
    tick();
    check("ovr_error", 32'(bus.monitor_error), 32'h1);
    av_rd(8'h40, rd, waits);
    check("ovr_first_kept", rd, 32'hBBBB_0001);
    av_rd(8'h41, rd, waits);
    check("ovr_second_dropped", rd, 32'h4141_4141);
    jtag(1, 0, 0, jdo_addr(8'h40, 1'b1));
    check("errclr", 32'(bus.monitor_error), 32'h0);

    // Simultaneous a and b: b loses and flags an error
    jtag(1, 1, 0, jdo_addr(8'h50, 1'b0));
    tick();
    check("prio_error", 32'(bus.monitor_error), 32'h1);
    jtag(1, 0, 0, jdo_addr(8'h50, 1'b1));

    // Avalon read contending with a pending JTAG read
    jtag(1, 0, 0, jdo_addr(8'h10, 1'b0));
    jtag(0, 0, 1, '0);
    av_rd(8'h20, rd, waits);
    check("cont_rdata", rd, 32'hCAFE_F00D);
    check("cont_waits", 32'(waits), 32'd3);
    check("cont_MonDReg", bus.MonDReg, 32'hDEAD_BEEF);
    check("cont_ready", 32'(bus.monitor_ready), 32'h1);

    // Address load on a completion edge beats the increment
    jtag(1, 0, 0, jdo_addr(8'h60, 1'b0));
    jtag(0, 1, 0, jdo_data(32'h6060_6060));
    jtag(1, 0, 0, jdo_addr(8'h70, 1'b0));
    check("ld_vs_done_ready", 32'(bus.monitor_ready), 32'h0);
    jtag(0, 0, 1, '0);
    tick();
    tick();
    check("ld_vs_done_addr", bus.MonDReg, 32'h7070_7070);

`ifdef OCIMEM_ROM_PROTECT_EN
    jtag(1, 0, 0, jdo_addr(8'h05, 1'b0));
    jtag(0, 1, 0, jdo_data(32'hA5A5_A5A5));
    tick();
    check("rom_error", 32'(bus.monitor_error), 32'h1);
    check("rom_ready", 32'(bus.monitor_ready), 32'h1);
    av_wr(8'h06, 32'h1234_5678, 4'hF);
    jtag(1, 0, 0, jdo_addr(8'h05, 1'b1));
`endif

    // Async reset with a JTAG read queued: request discarded
    jtag(1, 0, 0, jdo_addr(8'h70, 1'b0));
    jtag(0, 0, 1, '0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_waitrequest", 32'(bus.av_waitrequest), 32'h1);
    check("arst_ready", 32'(bus.monitor_ready), 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("arst_discard_ready", 32'(bus.monitor_ready), 32'h0);
    check("arst_discard_MonDReg", bus.MonDReg, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
